// File: rtl/lpif_slave_pkg.sv
// Shared link-word layout and pack/unpack helpers for the LPIF link wrappers.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package lpif_slave_pkg;

    localparam int STATE_BITS  = 4;
    localparam int PROTID_BITS = 2;
    localparam int DATA_BITS   = 64;
    localparam int CRC_BITS    = 4;
    localparam int WORD_BITS   = STATE_BITS + PROTID_BITS + DATA_BITS + CRC_BITS + 3;

    localparam int STATE_LSB  = 0;
    localparam int PROTID_LSB = 4;
    localparam int DATA_LSB   = 6;
    localparam int DVALID_BIT = 70;
    localparam int CRC_LSB    = 71;
    localparam int CRCV_BIT   = 75;
    localparam int VALID_BIT  = 76;

    // Declared MSB first so the packed image matches the LSB-first wire layout.
    typedef struct packed {
        logic                   valid;
        logic                   crc_valid;
        logic [CRC_BITS-1:0]    crc;
        logic                   dvalid;
        logic [DATA_BITS-1:0]   data;
        logic [PROTID_BITS-1:0] protid;
        logic [STATE_BITS-1:0]  state;
    } lpif_word_t;

    function automatic lpif_word_t lpif_pack(
        input logic [STATE_BITS-1:0]  state,
        input logic [PROTID_BITS-1:0] protid,
        input logic [DATA_BITS-1:0]   data,
        input logic                   dvalid,
        input logic [CRC_BITS-1:0]    crc,
        input logic                   crc_valid,
        input logic                   valid
    );
        lpif_word_t w;
        w.state     = state;
        w.protid    = protid;
        w.data      = data;
        w.dvalid    = dvalid;
        w.crc       = crc;
        w.crc_valid = crc_valid;
        w.valid     = valid;
        return w;
    endfunction

    function automatic lpif_word_t lpif_unpack(input logic [WORD_BITS-1:0] raw);
        lpif_word_t w;
        w.state     = raw[STATE_LSB  +: STATE_BITS];
        w.protid    = raw[PROTID_LSB +: PROTID_BITS];
        w.data      = raw[DATA_LSB   +: DATA_BITS];
        w.dvalid    = raw[DVALID_BIT];
        w.crc       = raw[CRC_LSB    +: CRC_BITS];
        w.crc_valid = raw[CRCV_BIT];
        w.valid     = raw[VALID_BIT];
        return w;
    endfunction

    // Idle filler: only the state field is meaningful, every valid bit is low.
    function automatic lpif_word_t lpif_idle(input logic [STATE_BITS-1:0] state);
        lpif_word_t w;
        w       = '0;
        w.state = state;
        return w;
    endfunction

endpackage

// File: rtl/lpif_skid2.sv
// Generic 2-entry valid/ready FIFO used as a skid buffer.
// Latency: 1 cycle from push to head; no combinational in->out path.
// Backpressure: in_rdy is registered, low while both entries are occupied.
module lpif_skid2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_vld,
    output logic         in_rdy,
    input  logic [W-1:0] in_dat,
    output logic         out_vld,
    input  logic         out_rdy,
    output logic [W-1:0] out_dat,
    output logic [1:0]   cnt
);

    logic [W-1:0] mem [0:1];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   cnt_q;
    logic [1:0]   cnt_nxt;
    logic         push;
    logic         pop;

    assign push    = in_vld & in_rdy;
    assign pop     = out_vld & out_rdy;
    assign out_vld = (cnt_q != 2'd0);
    assign out_dat = mem[rd_ptr];
    assign cnt     = cnt_q;

    // Occupancy only moves when exactly one of push/pop fires.
    always_comb begin
        cnt_nxt = cnt_q;
        case ({push, pop})
            2'b10:   cnt_nxt = cnt_q + 2'd1;
            2'b01:   cnt_nxt = cnt_q - 2'd1;
            default: cnt_nxt = cnt_q;
        endcase
    end

    // Storage, pointers, occupancy and the registered ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt_q  <= 2'd0;
            in_rdy <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_dat;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            cnt_q  <= cnt_nxt;
            in_rdy <= (cnt_nxt < 2'd2);
        end
    end

    a_cnt_range: assert property (@(posedge clk) disable iff (rst) cnt_q <= 2'd2);
    a_no_ovf:    assert property (@(posedge clk) disable iff (rst) !(push && !pop && cnt_q == 2'd2));
    a_no_unf:    assert property (@(posedge clk) disable iff (rst) !(pop && cnt_q == 2'd0));

endmodule

// File: rtl/lpif_txrx_x4_asym2_full_slave_pipe.sv
// Slave-side LPIF link wrapper: unpacks rx link words, packs tx beats with idle fill.
// Latency: RX 1 cycle; TX 1 cycle through a 2-entry skid FIFO.
// Backpressure: ustrm_ready registered, drops when the skid holds 2 words.
module lpif_txrx_x4_asym2_full_slave_pipe
    import lpif_slave_pkg::*;
#(
    parameter int STATE_W  = 4,
    parameter int PROTID_W = 2,
    parameter int DATA_W   = 64,
    parameter int CRC_W    = 4,
    parameter int WORD_W   = 77
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [WORD_W-1:0]   rxfifo_downstream_data,
    input  logic                rxfifo_downstream_vld,
    output logic [STATE_W-1:0]  dstrm_state,
    output logic [PROTID_W-1:0] dstrm_protid,
    output logic [DATA_W-1:0]   dstrm_data,
    output logic                dstrm_dvalid,
    output logic [CRC_W-1:0]    dstrm_crc,
    output logic                dstrm_crc_valid,
    output logic                dstrm_valid,
    output logic                dstrm_state_chg,
    input  logic [STATE_W-1:0]  ustrm_state,
    input  logic [PROTID_W-1:0] ustrm_protid,
    input  logic [DATA_W-1:0]   ustrm_data,
    input  logic                ustrm_dvalid,
    input  logic [CRC_W-1:0]    ustrm_crc,
    input  logic                ustrm_crc_valid,
    input  logic                ustrm_valid,
    output logic                ustrm_ready,
    output logic [WORD_W-1:0]   txfifo_upstream_data,
    output logic                txfifo_upstream_vld,
    input  logic                txfifo_upstream_ready,
    output logic [1:0]          tx_skid_cnt
);

    // The struct layout is fixed by the package; reject any other geometry.
    if (WORD_W != STATE_W + PROTID_W + DATA_W + CRC_W + 3 || WORD_W != WORD_BITS ||
        STATE_W != STATE_BITS || PROTID_W != PROTID_BITS || DATA_W != DATA_BITS ||
        CRC_W != CRC_BITS || VALID_BIT != WORD_W - 1) begin : g_bad_geometry
        $error("lpif_txrx_x4_asym2_full_slave_pipe: word geometry does not match lpif_word_t");
    end

    logic [1:0] rst_sync;
    logic       rst_int;

    // Assert immediately, release two clk edges after rst falls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rst_sync <= 2'b11;
        else     rst_sync <= {rst_sync[0], 1'b0};
    end
    assign rst_int = rst_sync[1];

    lpif_word_t rx_word;
    assign rx_word = lpif_unpack(rxfifo_downstream_data);

    // RX register stage: fields load on vld, qualifiers clear on gaps.
    always_ff @(posedge clk or posedge rst_int) begin
        if (rst_int) begin
            dstrm_state     <= '0;
            dstrm_protid    <= '0;
            dstrm_data      <= '0;
            dstrm_dvalid    <= 1'b0;
            dstrm_crc       <= '0;
            dstrm_crc_valid <= 1'b0;
            dstrm_valid     <= 1'b0;
            dstrm_state_chg <= 1'b0;
        end else if (rxfifo_downstream_vld) begin
            dstrm_state     <= rx_word.state;
            dstrm_protid    <= rx_word.protid;
            dstrm_data      <= rx_word.data;
            dstrm_dvalid    <= rx_word.dvalid;
            dstrm_crc       <= rx_word.crc;
            dstrm_crc_valid <= rx_word.crc_valid;
            dstrm_valid     <= rx_word.valid;
            dstrm_state_chg <= (rx_word.state != dstrm_state);
        end else begin
            dstrm_dvalid    <= 1'b0;
            dstrm_crc_valid <= 1'b0;
            dstrm_valid     <= 1'b0;
            dstrm_state_chg <= 1'b0;
        end
    end

    lpif_word_t          push_word;
    logic [WORD_W-1:0]   head_dat;
    logic                head_vld;
    logic                skid_pop_rdy;
    logic [STATE_W-1:0]  held_state;
    logic                tx_push;

    // Every accepted beat is a real flit, so its valid bit is forced high.
    assign push_word    = lpif_pack(ustrm_state, ustrm_protid, ustrm_data, ustrm_dvalid,
                                    ustrm_crc, ustrm_crc_valid, 1'b1);
    assign tx_push      = ustrm_valid & ustrm_ready;
    assign skid_pop_rdy = txfifo_upstream_vld & txfifo_upstream_ready;

    lpif_skid2 #(.W(WORD_W)) u_skid (
        .clk     (clk),
        .rst     (rst_int),
        .in_vld  (ustrm_valid),
        .in_rdy  (ustrm_ready),
        .in_dat  (push_word),
        .out_vld (head_vld),
        .out_rdy (skid_pop_rdy),
        .out_dat (head_dat),
        .cnt     (tx_skid_cnt)
    );

    // Last accepted state, carried by idle words.
    always_ff @(posedge clk or posedge rst_int) begin
        if (rst_int)      held_state <= '0;
        else if (tx_push) held_state <= ustrm_state;
    end

    // The tx side always presents a word once out of reset.
    always_ff @(posedge clk or posedge rst_int) begin
        if (rst_int) txfifo_upstream_vld <= 1'b0;
        else         txfifo_upstream_vld <= 1'b1;
    end

    // Only registered sources feed the output: skid head or idle filler.
    assign txfifo_upstream_data = head_vld ? head_dat : lpif_idle(held_state);

endmodule

// File: tb/tb_lpif_txrx_x4_asym2_full_slave_pipe.sv
module tb_lpif_txrx_x4_asym2_full_slave_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [76:0] rx_dat = '0;
    logic        rx_vld = 1'b0;
    logic [3:0]  dstrm_state;
    logic [1:0]  dstrm_protid;
    logic [63:0] dstrm_data;
    logic        dstrm_dvalid;
    logic [3:0]  dstrm_crc;
    logic        dstrm_crc_valid;
    logic        dstrm_valid;
    logic        dstrm_state_chg;
    logic [3:0]  u_state = '0;
    logic [1:0]  u_protid = '0;
    logic [63:0] u_data = '0;
    logic        u_dvalid = 1'b0;
    logic [3:0]  u_crc = '0;
    logic        u_crcv = 1'b0;
    logic        u_valid = 1'b0;
    logic        ustrm_ready;
    logic [76:0] txfifo_upstream_data;
    logic        txfifo_upstream_vld;
    logic        tx_rdy = 1'b0;
    logic [1:0]  tx_skid_cnt;

    always #5 clk = ~clk;

    lpif_txrx_x4_asym2_full_slave_pipe dut (
        .clk                    (clk),
        .rst                    (rst),
        .rxfifo_downstream_data (rx_dat),
        .rxfifo_downstream_vld  (rx_vld),
        .dstrm_state            (dstrm_state),
        .dstrm_protid           (dstrm_protid),
        .dstrm_data             (dstrm_data),
        .dstrm_dvalid           (dstrm_dvalid),
        .dstrm_crc              (dstrm_crc),
        .dstrm_crc_valid        (dstrm_crc_valid),
        .dstrm_valid            (dstrm_valid),
        .dstrm_state_chg        (dstrm_state_chg),
        .ustrm_state            (u_state),
        .ustrm_protid           (u_protid),
        .ustrm_data             (u_data),
        .ustrm_dvalid           (u_dvalid),
        .ustrm_crc              (u_crc),
        .ustrm_crc_valid        (u_crcv),
        .ustrm_valid            (u_valid),
        .ustrm_ready            (ustrm_ready),
        .txfifo_upstream_data   (txfifo_upstream_data),
        .txfifo_upstream_vld    (txfifo_upstream_vld),
        .txfifo_upstream_ready  (tx_rdy),
        .tx_skid_cnt            (tx_skid_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: tx FIFO contents as a queue, last accepted state, rx view.
    logic [76:0] tx_q[$];
    logic [76:0] offered[$];
    logic [76:0] dut_out[$];
    logic [3:0]  last_state = '0;
    logic [76:0] m_rx = '0;   // last loaded rx word fields
    logic        m_dv = 1'b0, m_cv = 1'b0, m_v = 1'b0, m_chg = 1'b0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [76:0] beat_word();
        return {1'b1, u_crcv, u_crc, u_dvalid, u_data, u_protid, u_state};
    endfunction

    task automatic rand_beat();
        u_state  = 4'($urandom);
        u_protid = 2'($urandom);
        u_data   = {$urandom, $urandom};
        u_dvalid = 1'($urandom);
        u_crc    = 4'($urandom);
        u_crcv   = 1'($urandom);
    endtask

    task automatic model_reset();
        tx_q.delete();
        offered.delete();
        dut_out.delete();
        last_state = '0;
        m_rx = '0;
        m_dv = 1'b0; m_cv = 1'b0; m_v = 1'b0; m_chg = 1'b0;
    endtask

    // One clock: check tx outputs before the edge, advance model, check rx after.
    task automatic cycle(output bit pushed);
        logic [76:0] exp_tx;
        bit          push, pop, rv;
        logic [76:0] rw;
        exp_tx = (tx_q.size() == 0) ? {73'd0, last_state} : tx_q[0];
        chk("tx_vld", txfifo_upstream_vld, 1'b1);
        chk("tx_data", txfifo_upstream_data, exp_tx);
        chk("ustrm_ready", ustrm_ready, (tx_q.size() < 2));
        chk("skid_cnt", tx_skid_cnt, tx_q.size());
        if (tx_rdy && txfifo_upstream_vld && txfifo_upstream_data[76])
            dut_out.push_back(txfifo_upstream_data);
        push = u_valid && (tx_q.size() < 2);
        pop  = tx_rdy && (tx_q.size() != 0);
        rv = rx_vld;
        rw = rx_dat;
        @(posedge clk);
        if (pop) void'(tx_q.pop_front());
        if (push) begin
            tx_q.push_back(beat_word());
            offered.push_back(beat_word());
            last_state = u_state;
        end
        if (rv) begin
            m_chg = (rw[3:0] != m_rx[3:0]);
            m_rx  = rw;
            m_dv  = rw[70];
            m_cv  = rw[75];
            m_v   = rw[76];
        end else begin
            m_dv = 1'b0; m_cv = 1'b0; m_v = 1'b0; m_chg = 1'b0;
        end
        pushed = push;
        #1;
        chk("dstrm_state", dstrm_state, m_rx[3:0]);
        chk("dstrm_protid", dstrm_protid, m_rx[5:4]);
        chk("dstrm_data", dstrm_data, m_rx[69:6]);
        chk("dstrm_crc", dstrm_crc, m_rx[74:71]);
        chk("dstrm_dvalid", dstrm_dvalid, m_dv);
        chk("dstrm_crc_valid", dstrm_crc_valid, m_cv);
        chk("dstrm_valid", dstrm_valid, m_v);
        chk("dstrm_state_chg", dstrm_state_chg, m_chg);
    endtask

    // Drain, then compare the real words the DUT emitted against those accepted.
    task automatic compare_streams(input string tag);
        bit p;
        u_valid = 1'b0;
        tx_rdy  = 1'b1;
        rx_vld  = 1'b0;
        repeat (3) cycle(p);
        chk({tag, "_count"}, dut_out.size(), offered.size());
        for (int i = 0; i < offered.size() && i < dut_out.size(); i++)
            chk({tag, "_order"}, dut_out[i], offered[i]);
        offered.delete();
        dut_out.delete();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_dstrm"}, {dstrm_state, dstrm_protid, dstrm_data, dstrm_dvalid, dstrm_crc,
                              dstrm_crc_valid, dstrm_valid, dstrm_state_chg}, '0);
        chk({tag, "_tx_vld"}, txfifo_upstream_vld, 1'b0);
        chk({tag, "_tx_data"}, txfifo_upstream_data, '0);
        chk({tag, "_cnt"}, tx_skid_cnt, 2'd0);
        chk({tag, "_ready"}, ustrm_ready, 1'b0);
    endtask

    task automatic check_after_release(input string tag);
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_tx_vld"}, txfifo_upstream_vld, 1'b1);
        chk({tag, "_tx_data"}, txfifo_upstream_data, '0);
        chk({tag, "_ready"}, ustrm_ready, 1'b1);
        chk({tag, "_cnt"}, tx_skid_cnt, 2'd0);
    endtask

    initial begin
        bit p;
        p = 1'b1;
        // Power-on reset
        #1 rst = 1'b1;
        #1 check_all_zero("por");
        #10 rst = 1'b0;
        check_after_release("por_rel");

        // RX unpack, repeat, gap
        rx_vld = 1'b1;
        rx_dat = {1'b1, 1'b1, 4'hA, 1'b1, 64'hDEAD_BEEF_0123_4567, 2'b01, 4'h3};
        cycle(p);
        chk("rx_first_chg", dstrm_state_chg, 1'b1);
        chk("rx_first_data", dstrm_data, 64'hDEAD_BEEF_0123_4567);
        cycle(p);
        chk("rx_repeat_chg", dstrm_state_chg, 1'b0);
        rx_vld = 1'b0;
        cycle(p);
        chk("rx_gap_valid", {dstrm_valid, dstrm_dvalid, dstrm_crc_valid}, 3'b000);
        chk("rx_gap_state", dstrm_state, 4'h3);

        // TX backpressure: A, B fill the skid, C waits at its source
        tx_rdy  = 1'b0;
        u_valid = 1'b1;
        rand_beat(); cycle(p);
        rand_beat(); cycle(p);
        rand_beat(); cycle(p);
        chk("bp_c_not_taken", p, 1'b0);
        chk("bp_cnt", tx_skid_cnt, 2'd2);
        chk("bp_ready", ustrm_ready, 1'b0);
        tx_rdy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle(p);
            if (p) u_valid = 1'b0;
        end
        compare_streams("bp");

        // Simultaneous push/pop at occupancy 1
        tx_rdy  = 1'b0;
        u_valid = 1'b1;
        rand_beat(); cycle(p);
        tx_rdy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            rand_beat();
            cycle(p);
            chk("simul_cnt", tx_skid_cnt, 2'd1);
        end
        compare_streams("simul");

        // Idle insertion after a single beat
        tx_rdy  = 1'b1;
        u_valid = 1'b1;
        rand_beat();
        u_state = 4'h5;
        cycle(p);
        u_valid = 1'b0;
        cycle(p);
        chk("idle_valid_bit", txfifo_upstream_data[76], 1'b0);
        chk("idle_state", txfifo_upstream_data[3:0], 4'h5);
        chk("idle_data", txfifo_upstream_data[69:6], 64'd0);
        compare_streams("idle");

        // Randomized traffic on both paths
        p = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (!u_valid || p) begin
                u_valid = 1'($urandom);
                rand_beat();
            end
            tx_rdy = ($urandom_range(0, 3) != 0);
            rx_vld = 1'($urandom);
            rx_dat = {13'($urandom), $urandom, $urandom};
            cycle(p);
        end
        compare_streams("rand");

        // Mid-traffic reset with the skid full
        tx_rdy  = 1'b0;
        u_valid = 1'b1;
        rx_vld  = 1'b1;
        rx_dat  = {1'b1, 1'b1, 4'hF, 1'b1, 64'h1234_5678_9ABC_DEF0, 2'b11, 4'h9};
        rand_beat(); cycle(p);
        rand_beat(); cycle(p);
        chk("mid_cnt_full", tx_skid_cnt, 2'd2);
        #3 rst = 1'b1;
        #1 check_all_zero("mid");
        u_valid = 1'b0;
        rx_vld  = 1'b0;
        model_reset();
        @(posedge clk);
        #2 rst = 1'b0;
        check_after_release("mid_rel");
        p = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (!u_valid || p) begin
                u_valid = 1'($urandom);
                rand_beat();
            end
            tx_rdy = 1'($urandom);
            rx_vld = 1'($urandom);
            rx_dat = {13'($urandom), $urandom, $urandom};
            cycle(p);
        end
        compare_streams("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
